// File: rtl/i2c_ram_write_arbiter.sv
// Write-port arbiter for the 32x8 slave-data RAM: I2C master, menu edits and a sequenced clear.
// Define RAM_ARB_RR_EN for round-robin between mst and menu; default is fixed mst > menu > clear.
module i2c_ram_write_arbiter #(
   parameter int unsigned        ADDR_W     = 5,
   parameter int unsigned        DATA_W     = 8,
   parameter int unsigned        DEPTH      = 32,
   parameter logic [DATA_W-1:0]  CLEAR_CHAR = DATA_W'(8'h20)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mst_req,
   input  logic [ADDR_W-1:0] mst_addr,
   input  logic [DATA_W-1:0] mst_data,
   output logic              mst_gnt,
   input  logic              menu_req,
   input  logic [ADDR_W-1:0] menu_addr,
   input  logic [DATA_W-1:0] menu_data,
   output logic              menu_gnt,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
`ifdef RAM_ARB_RR_EN
   logic             r_rr_menu;
`endif

   logic             w_mst_ok;
   logic             w_menu_ok;
   logic             w_pick_mst;
   logic             w_pick_menu;
   logic             w_clr_act;
   logic             w_clr_wr;
   logic             w_clr_last;
   logic [CNT_W-1:0] w_cnt;

   // A requester granted last cycle sits out this sampling edge.
   assign w_mst_ok  = mst_req  && !mst_gnt;
   assign w_menu_ok = menu_req && !menu_gnt;

`ifdef RAM_ARB_RR_EN
   assign w_pick_mst = w_mst_ok && !(w_menu_ok && r_rr_menu);
`else
   assign w_pick_mst = w_mst_ok;
`endif
   assign w_pick_menu = w_menu_ok && !w_pick_mst;

   // The clear issues address 0 on the same edge that accepts clear_start, so busy covers exactly the writes.
   assign w_clr_act  = (r_state == S_CLEAR) || ((r_state == S_IDLE) && clear_start);
   assign w_cnt      = (r_state == S_CLEAR) ? r_cnt : '0;
   assign w_clr_wr   = w_clr_act && !w_mst_ok && !w_menu_ok;
   assign w_clr_last = (w_cnt == CNT_W'(DEPTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
`ifdef RAM_ARB_RR_EN
         r_rr_menu  <= 1'b0;
`endif
         mst_gnt    <= 1'b0;
         menu_gnt   <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         ram_we     <= 1'b0;
         ram_waddr  <= '0;
         ram_wdata  <= '0;
      end else begin
         mst_gnt    <= w_pick_mst;
         menu_gnt   <= w_pick_menu;
         ram_we     <= w_pick_mst || w_pick_menu || w_clr_wr;
         clear_busy <= w_clr_act;
         clear_done <= (r_state == S_DONE);

`ifdef RAM_ARB_RR_EN
         if (w_pick_mst || w_pick_menu) r_rr_menu <= w_pick_mst;
`endif

         if (w_pick_mst) begin
            ram_waddr <= mst_addr;
            ram_wdata <= mst_data;
         end else if (w_pick_menu) begin
            ram_waddr <= menu_addr;
            ram_wdata <= menu_data;
         end else if (w_clr_wr) begin
            ram_waddr <= ADDR_W'(w_cnt);
            ram_wdata <= CLEAR_CHAR;
         end else begin
            ram_waddr <= '0;
            ram_wdata <= '0;
         end

         // A stalled clear holds its count, so it resumes at the same address.
         case (r_state)
            S_IDLE, S_CLEAR: begin
               if (w_clr_act) begin
                  r_state <= S_CLEAR;
                  r_cnt   <= w_cnt;
                  if (w_clr_wr) begin
                     if (w_clr_last) r_state <= S_DONE;
                     else            r_cnt   <= w_cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_ram_write_arbiter.sv
// Directed self-checking bench for i2c_ram_write_arbiter (expected values hand-derived).
module tb_i2c_ram_write_arbiter;

   logic       clk;
   logic       reset;
   logic       mst_req;
   logic [4:0] mst_addr;
   logic [7:0] mst_data;
   logic       mst_gnt;
   logic       menu_req;
   logic [4:0] menu_addr;
   logic [7:0] menu_data;
   logic       menu_gnt;
   logic       clear_start;
   logic       clear_busy;
   logic       clear_done;
   logic       ram_we;
   logic [4:0] ram_waddr;
   logic [7:0] ram_wdata;

   int n_chk = 0;
   int n_err = 0;

   // clear-traffic monitor tallies
   bit mon_en = 0;
   int cyc = 0;
   int n_clr, n_bad, n_busy, n_done, n_mgnt, last_clr_cyc, done_cyc;

   i2c_ram_write_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .mst_req    (mst_req),
      .mst_addr   (mst_addr),
      .mst_data   (mst_data),
      .mst_gnt    (mst_gnt),
      .menu_req   (menu_req),
      .menu_addr  (menu_addr),
      .menu_data  (menu_data),
      .menu_gnt   (menu_gnt),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .ram_we     (ram_we),
      .ram_waddr  (ram_waddr),
      .ram_wdata  (ram_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Clear writes must walk 0..31 in order, one each, with CLEAR_CHAR and busy high.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         if (clear_busy) n_busy++;
         if (clear_done) begin n_done++; done_cyc = cyc; end
         if (mst_gnt) n_mgnt++;
         if (mst_gnt && menu_gnt) n_bad++;
         if (ram_we && !mst_gnt && !menu_gnt) begin
            if (int'(ram_waddr) != n_clr) n_bad++;
            if (ram_wdata != 8'h20) n_bad++;
            if (!clear_busy) n_bad++;
            n_clr++;
            last_clr_cyc = cyc;
         end
      end
   end

   task automatic mon_start();
      n_clr = 0; n_bad = 0; n_busy = 0; n_done = 0; n_mgnt = 0;
      last_clr_cyc = 0; done_cyc = 0;
      mon_en = 1;
   endtask

   task automatic pulse_clear();
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
   endtask

   task automatic wait_clr_addr(input int a, input string tag);
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ram_we && !mst_gnt && !menu_gnt && int'(ram_waddr) == a) begin
            found = 1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (clear_done) begin found = 1; break; end
      end
      chk(tag, 32'(found), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; mst_req = 0; mst_addr = 0; mst_data = 0;
      menu_req = 0; menu_addr = 0; menu_data = 0; clear_start = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_gnts", 32'({mst_gnt, menu_gnt}), 0);
      chk("rst_clear", 32'({clear_busy, clear_done}), 0);
      chk("rst_addr_data", 32'({ram_waddr, ram_wdata}), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single menu write
      menu_req = 1; menu_addr = 5'd5; menu_data = 8'h41;
      @(negedge clk);
      chk("menu_gnt", 32'(menu_gnt), 1);
      chk("menu_mst_gnt", 32'(mst_gnt), 0);
      chk("menu_we", 32'(ram_we), 1);
      chk("menu_addr", 32'(ram_waddr), 5);
      chk("menu_data", 32'(ram_wdata), 32'h41);
      menu_req = 0;
      @(negedge clk);
      chk("menu_we_off", 32'(ram_we), 0);
      chk("menu_gnt_off", 32'(menu_gnt), 0);

      // simultaneous mst/menu held: mst, menu, mst
      mst_req = 1; mst_addr = 5'd3; mst_data = 8'h11;
      menu_req = 1; menu_addr = 5'd4; menu_data = 8'h22;
      @(negedge clk);
      chk("both_c1_gnts", 32'({mst_gnt, menu_gnt}), 32'b10);
      chk("both_c1_wr", 32'({ram_we, ram_waddr, ram_wdata}), {19'd0, 1'b1, 5'd3, 8'h11});
      @(negedge clk);
      chk("both_c2_gnts", 32'({mst_gnt, menu_gnt}), 32'b01);
      chk("both_c2_wr", 32'({ram_we, ram_waddr, ram_wdata}), {19'd0, 1'b1, 5'd4, 8'h22});
      @(negedge clk);
      chk("both_c3_gnts", 32'({mst_gnt, menu_gnt}), 32'b10);
      mst_req = 0; menu_req = 0;
      @(negedge clk);
      chk("both_idle_we", 32'(ram_we), 0);
      // fresh tie after mst was granted last
      mst_req = 1; menu_req = 1;
      @(negedge clk);
`ifdef RAM_ARB_RR_EN
      chk("tie_after_mst", 32'({mst_gnt, menu_gnt}), 32'b01);
`else
      chk("tie_after_mst", 32'({mst_gnt, menu_gnt}), 32'b10);
`endif
      mst_req = 0; menu_req = 0;
      repeat (3) @(negedge clk);

      // clear with no traffic
      mon_start();
      pulse_clear();
      chk("clr_first_busy", 32'(clear_busy), 1);
      chk("clr_first_wr", 32'({ram_we, ram_waddr, ram_wdata}), {19'd0, 1'b1, 5'd0, 8'h20});
      wait_done("clr_done_seen");
      chk("clr_writes", 32'(n_clr), 32);
      chk("clr_bad", 32'(n_bad), 0);
      chk("clr_busy_cycles", 32'(n_busy), 32);
      chk("clr_done_count", 32'(n_done), 1);
      chk("clr_done_after_last", 32'(done_cyc - last_clr_cyc), 1);
      chk("clr_idle_busy", 32'(clear_busy), 0);

      // clear stalled by 4 mst grants starting at clear_cnt=10
      mon_start();
      pulse_clear();
      wait_clr_addr(9, "stall_reach9");
      mst_req = 1; mst_addr = 5'd7; mst_data = 8'h55;
      begin
         int g = 0;
         for (int i = 0; i < 50 && g < 4; i++) begin
            @(negedge clk);
            if (mst_gnt) g++;
         end
         chk("stall_grants_seen", 32'(g), 4);
      end
      mst_req = 0;
      wait_done("stall_done_seen");
      chk("stall_writes", 32'(n_clr), 32);
      chk("stall_bad", 32'(n_bad), 0);
      chk("stall_busy_cycles", 32'(n_busy), 36);
      chk("stall_mst_grants", 32'(n_mgnt), 4);
      chk("stall_done_count", 32'(n_done), 1);

      // reset mid-clear at clear_cnt=17
      mon_start();
      pulse_clear();
      wait_clr_addr(16, "rstmid_reach16");
      reset = 1'b1;
      #1;
      chk("rstmid_async_we", 32'(ram_we), 0);
      chk("rstmid_async_busy", 32'(clear_busy), 0);
      chk("rstmid_async_addr", 32'(ram_waddr), 0);
      mst_req = 1;
      repeat (2) @(negedge clk);
      chk("rstmid_no_gnt", 32'(mst_gnt), 0);
      mst_req = 0;
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("rstmid_writes", 32'(n_clr), 17);
      chk("rstmid_no_done", 32'(n_done), 0);
      chk("rstmid_idle_busy", 32'(clear_busy), 0);
      mon_start();
      pulse_clear();
      chk("restart_first_addr", 32'({ram_we, ram_waddr}), {26'd0, 1'b1, 5'd0});
      wait_done("restart_done_seen");
      chk("restart_writes", 32'(n_clr), 32);
      chk("restart_bad", 32'(n_bad), 0);

      // clear_start re-pulsed at clear_cnt=8 is ignored
      mon_start();
      pulse_clear();
      wait_clr_addr(7, "repulse_reach7");
      pulse_clear();
      wait_done("repulse_done_seen");
      repeat (40) @(negedge clk);
      chk("repulse_writes", 32'(n_clr), 32);
      chk("repulse_bad", 32'(n_bad), 0);
      chk("repulse_busy_cycles", 32'(n_busy), 32);
      chk("repulse_done_count", 32'(n_done), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_ram_write_arbiter.md
Name: i2c_ram_write_arbiter

Overview:
- Arbitrates the single write port of the 32x8 slave-data RAM between three sources:
  - I2C master receive path (bytes read from the slave);
  - menu controller edits;
  - an internal clear sequencer that fills every location with a blank character.
- Sits between the I2C master core / menu controller and the RAM controller's write port.
- Replaces the single-cycle bulk clear with a sequenced one-address-per-cycle clear.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 32, number of locations cleared (addresses 0..DEPTH-1).
- CLEAR_CHAR, 8'h20, byte written by the clear sequencer (ASCII space).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mst_req  in  1  I2C master write request; hold with addr/data stable until mst_gnt.
- mst_addr  in  ADDR_W  I2C master write address.
- mst_data  in  DATA_W  I2C master write data.
- mst_gnt  out  1  one-cycle grant; the write is on the RAM port this cycle.
- menu_req  in  1  menu write request; same rules as mst_req.
- menu_addr  in  ADDR_W  menu write address.
- menu_data  in  DATA_W  menu write data.
- menu_gnt  out  1  one-cycle grant for the menu request.
- clear_start  in  1  single-cycle pulse; begins a full clear.
- clear_busy  out  1  high while a clear is in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Requests are sampled at posedge N. The winning write appears on ram_we/ram_waddr/ram_wdata with its gnt in cycle N+1 (1-cycle latency).
- At most one write per cycle. ram_we=1 exactly when one gnt is high or a clear write is issued.
- No back-to-back grants to the same requester: a requester granted in cycle N is ineligible at the posedge ending cycle N. Its max rate is 1 write per 2 cycles.
- The requester must deassert req, or present new addr/data, on seeing gnt.
- Priority (default): mst > menu > clear. Losing requests stay pending; there is no timeout.
- Clear FSM:
  - IDLE -> CLEAR on clear_start. clear_cnt=0, clear_busy=1 from the next cycle.
  - CLEAR: when neither mst nor menu wins, issue a write of CLEAR_CHAR at clear_cnt and increment clear_cnt. When clear_cnt==DEPTH-1 is written, go to DONE.
  - DONE: clear_done=1 and clear_busy=0 for one cycle, then IDLE.
- clear_start while in CLEAR or DONE is ignored; there is no restart.
- A clear stalled by higher-priority traffic resumes at the same address with no skips.
- A mst/menu write during a clear goes to RAM as issued. If it hits an address not yet cleared, the clear later overwrites it (accepted behaviour).
- Counter is ADDR_W+1 bits. Wrap past DEPTH-1 is impossible; the FSM leaves CLEAR first.
- Reset mid-clear: abort immediately, FSM to IDLE, no clear_done, RAM contents partially cleared.
- Requests asserted during reset are not granted until after reset deasserts.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: mst and menu are arbitrated round-robin. The last-granted of the two has lower priority on the next tie. Clear stays lowest. The RR pointer resets to favour mst.
- Undefined: fixed priority mst > menu > clear as above.

Test Plan:
- Single menu write: menu_req=1, addr=5, data=8'h41 -> one cycle later menu_gnt=1, ram_we=1, ram_waddr=5, ram_wdata=8'h41; then ram_we=0.
- Simultaneous mst (addr 3, 8'h11) and menu (addr 4, 8'h22) held high -> fixed priority: mst granted cycle 1, menu cycle 2, mst cycle 3 (alternating via the no-back-to-back rule). With RAM_ARB_RR_EN: alternating starting with mst.
- Clear with no traffic: clear_start pulse -> 32 consecutive writes of 8'h20 to addresses 0..31; clear_done high one cycle after address 31; clear_busy high for exactly 32 cycles.
- Clear stalled: mst_req held for 4 grants starting at clear_cnt=10 -> clear writes resume at address 10. Total clear duration is 32 plus the number of stall cycles. Every address 0..31 is written exactly once by the clear.
- Reset mid-clear at clear_cnt=17 -> all outputs 0 asynchronously, clear_done never pulses. A new clear_start after reset restarts from address 0.
- clear_start re-pulsed at clear_cnt=8 -> ignored; the single clear completes with exactly one clear_done.
